// File: rtl/alu_dispatch.sv
// alu_dispatch: queues instructions in a small FIFO and issues them one at a
// time to an external combinational ALU, then holds each registered result
// on a valid/ready handshake until the consumer takes it.
module alu_dispatch #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clock_in,
   input  logic       reset_n_in,
   // upstream instruction handshake and payload
   input  logic       instr_valid_in,
   output logic       instr_ready_out,
   input  logic [7:0] instr_opcode_in,
   input  logic [7:0] instr_operand1_in,
   input  logic [7:0] instr_operand2_in,
   // drive to / result from the combinational ALU
   output logic       alu_enable_out,
   output logic [7:0] alu_opcode_out,
   output logic [7:0] alu_input1_out,
   output logic [7:0] alu_input2_out,
   input  logic [7:0] alu_output_in,
   // downstream result handshake
   output logic       result_valid_out,
   input  logic       result_ready_in,
   output logic [7:0] result_data_out,
   output logic       illegal_op_out,
   output logic       busy_out
);

   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0]  MAX_OP  = 8'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_HOLD
   } state_e;

   state_e        state_q, state_d;

   // FIFO storage and bookkeeping; entry layout is {opcode, operand1, operand2}
   logic [23:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   // registered result and its qualifier
   logic [7:0]    result_q, result_d;
   logic          illegal_q, illegal_d;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [23:0]   head;
   logic [7:0]    head_op;
   logic [7:0]    head_a;
   logic [7:0]    head_b;

   assign fifo_full       = (count_q == DEPTH_C);
   assign fifo_empty      = (count_q == '0);
   assign instr_ready_out = !fifo_full;
   assign push            = instr_valid_in && !fifo_full;
   // ISSUE is only entered with a non-empty FIFO, so leaving it always pops
   assign pop             = (state_q == ST_ISSUE);
   assign head            = mem_q[rptr_q];
   assign head_op         = head[23:16];
   assign head_a          = head[15:8];
   assign head_b          = head[7:0];

   // FIFO pointer and occupancy next-state
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO payload storage; contents are don't-care while unoccupied
   always_ff @(posedge clock_in) begin
      if (push) begin
         mem_q[wptr_q] <= {instr_opcode_in, instr_operand1_in, instr_operand2_in};
      end
   end

   // FSM next-state and result capture
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            result_d  = alu_output_in;
            illegal_d = (head_op > MAX_OP);
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            // look ahead at this edge's push so a just-arriving instruction
            // is issued without an idle bubble
            if (result_ready_in) begin
               state_d = (!fifo_empty || push) ? ST_ISSUE : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ALU drive and status outputs
   always_comb begin
      alu_enable_out   = 1'b0;
      alu_opcode_out   = '0;
      alu_input1_out   = '0;
      alu_input2_out   = '0;
      if (state_q == ST_ISSUE) begin
         alu_enable_out = 1'b1;
         alu_opcode_out = head_op;
         alu_input1_out = head_a;
         alu_input2_out = head_b;
      end
      result_valid_out = (state_q == ST_HOLD);
      result_data_out  = result_q;
      illegal_op_out   = illegal_q;
      busy_out         = !fifo_empty || (state_q != ST_IDLE);
   end

   // state, pointer and result registers with asynchronous clear
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q   <= ST_IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: drives alu_dispatch with a behavioural ALU attached and
// scoreboards every delivered result against the order of acceptance.
module tb_alu_dispatch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] op, opa, opb;
   logic       alu_en;
   logic [7:0] alu_op, alu_a, alu_b, alu_out;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       illegal, busy;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int n_results = 0;
   logic [8:0] exp_q[$];   // {illegal, data}
   int res_cycles[$];

   // reference ALU: 0 ADD, 1 SUB, 2 MULTIPLY, 3 EQUALS, 4 AND, others 0
   function automatic logic [7:0] alu_model(input logic [7:0] o, x, y);
      logic [15:0] p;
      p = x * y;
      case (o)
         8'd0:    return x + y;
         8'd1:    return x - y;
         8'd2:    return p[7:0];
         8'd3:    return {7'b0, x == y};
         8'd4:    return x & y;
         default: return 8'd0;
      endcase
   endfunction

   assign alu_out = alu_model(alu_op, alu_a, alu_b);

   alu_dispatch #(.FIFO_DEPTH(4)) dut (
      .clock_in          (clk),
      .reset_n_in        (rst_n),
      .instr_valid_in    (instr_valid),
      .instr_ready_out   (instr_ready),
      .instr_opcode_in   (op),
      .instr_operand1_in (opa),
      .instr_operand2_in (opb),
      .alu_enable_out    (alu_en),
      .alu_opcode_out    (alu_op),
      .alu_input1_out    (alu_a),
      .alu_input2_out    (alu_b),
      .alu_output_in     (alu_out),
      .result_valid_out  (res_valid),
      .result_ready_in   (res_ready),
      .result_data_out   (res_data),
      .illegal_op_out    (illegal),
      .busy_out          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard pop: a handshake completes on the coming rising edge
   always @(negedge clk) begin : monitor
      logic [8:0] e;
      if (rst_n && res_valid && res_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got data=%0d illegal=%0b, required no result", res_data, illegal);
         end else begin
            e = exp_q.pop_front();
            if ({illegal, res_data} !== e) begin
               failures++;
               $display("FAIL result_order: got illegal=%0b data=%0d, required illegal=%0b data=%0d",
                        illegal, res_data, e[8], e[7:0]);
            end
         end
         n_results++;
         res_cycles.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [7:0] o, x, y);
      int n = 0;
      instr_valid = 1'b1;
      op = o; opa = x; opb = y;
      while (!instr_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!instr_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout: got instr_ready=0, required 1 within 100 cycles");
      end else begin
         exp_q.push_back({o > 8'd4, alu_model(o, x, y)});
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got busy=%0b pending=%0d, required busy=0 pending=0",
                  busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; op = '0; opa = '0; opb = '0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({instr_ready, busy, res_valid, illegal, alu_en} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_flags: got ready,busy,valid,illegal,en=%b, required 10000",
                  {instr_ready, busy, res_valid, illegal, alu_en});
      end
      checks++;
      if ({res_data, alu_op, alu_a, alu_b} !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: got %h, required 00000000", {res_data, alu_op, alu_a, alu_b});
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      res_ready = 1'b1;
      send(8'd0, 8'd200, 8'd100);
      checks++;
      if (alu_en !== 1'b0 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_e0: got en=%b valid=%b, required 0 0", alu_en, res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({alu_en, alu_op, alu_a, alu_b, res_valid} !== {1'b1, 8'd0, 8'd200, 8'd100, 1'b0}) begin
         failures++;
         $display("FAIL single_issue: got en=%b op=%0d a=%0d b=%0d valid=%b, required 1 0 200 100 0",
                  alu_en, alu_op, alu_a, alu_b, res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_data, illegal} !== {1'b1, 8'd44, 1'b0}) begin
         failures++;
         $display("FAIL single_result: got valid=%b data=%0d illegal=%b, required 1 44 0",
                  res_valid, res_data, illegal);
      end
      checks++;
      if ({alu_en, alu_op, alu_a, alu_b} !== 25'h0) begin
         failures++;
         $display("FAIL single_alu_idle: got en=%b op=%0d a=%0d b=%0d, required all 0",
                  alu_en, alu_op, alu_a, alu_b);
      end
      wait_idle(20);
   endtask

   task automatic test_backpressure();
      int n0;
      n0 = n_results;
      res_ready = 1'b0;
      send(8'd0, 8'd1, 8'd2);
      send(8'd1, 8'd10, 8'd3);
      send(8'd2, 8'd3, 8'd4);
      send(8'd3, 8'd9, 8'd9);
      send(8'd4, 8'hF0, 8'h3C);
      instr_valid = 1'b1; op = 8'd0; opa = 8'd99; opb = 8'd99;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({instr_ready, res_valid, res_data, busy} !== {1'b0, 1'b1, 8'd3, 1'b1}) begin
            failures++;
            $display("FAIL full_hold: got ready=%b valid=%b data=%0d busy=%b, required 0 1 3 1",
                     instr_ready, res_valid, res_data, busy);
         end
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      res_ready = 1'b1;
      wait_idle(60);
      checks++;
      if (n_results - n0 !== 5) begin
         failures++;
         $display("FAIL full_drain_count: got %0d results, required 5", n_results - n0);
      end
   endtask

   task automatic test_push_pop();
      int n;
      res_ready = 1'b0;
      send(8'd0, 8'd5, 8'd6);
      send(8'd1, 8'd50, 8'd7);
      send(8'd4, 8'hAA, 8'h0F);
      res_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         n = 0;
         while (!alu_en && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if (alu_en !== 1'b1 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_ready: got en=%b ready=%b, required 1 1", alu_en, instr_ready);
         end
         send(8'(i % 5), 8'(i * 7 + 1), 8'(i + 3));
         checks++;
         if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_occupancy: got ready=%b, required 1", instr_ready);
         end
      end
      wait_idle(40);
   endtask

   task automatic test_illegal();
      int n;
      res_ready = 1'b1;
      send(8'd7, 8'd3, 8'd4);
      send(8'd3, 8'd5, 8'd5);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if (k == 0 && {res_valid, res_data, illegal} !== {1'b1, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_op: got valid=%b data=%0d illegal=%b, required 1 0 1",
                     res_valid, res_data, illegal);
         end
         if (k == 1 && {res_valid, res_data, illegal} !== {1'b1, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL equals_after_illegal: got valid=%b data=%0d illegal=%b, required 1 1 0",
                     res_valid, res_data, illegal);
         end
         @(posedge clk); #1;
      end
      wait_idle(20);
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b0;
      send(8'd0, 8'd1, 8'd1);
      send(8'd0, 8'd2, 8'd2);
      send(8'd0, 8'd3, 8'd3);
      send(8'd0, 8'd4, 8'd4);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({res_valid, res_data, illegal, alu_en, alu_op, busy, instr_ready} !== {1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_async: got valid=%b data=%0d illegal=%b en=%b op=%0d busy=%b ready=%b, required 0 0 0 0 0 0 1",
                  res_valid, res_data, illegal, alu_en, alu_op, busy, instr_ready);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({res_valid, busy, instr_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_discard: got valid=%b busy=%b ready=%b, required 0 0 1",
                     res_valid, busy, instr_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1;
      res_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         send(8'd2, 8'd16, 8'd17);
      end
      wait_idle(60);
      checks++;
      if (res_cycles.size() != 8) begin
         failures++;
         $display("FAIL stream_count: got %0d results, required 8", res_cycles.size());
      end else begin
         for (int i = 1; i < 8; i++) begin
            checks++;
            if (res_cycles[i] - res_cycles[i-1] != 2) begin
               failures++;
               $display("FAIL stream_spacing: got %0d cycles between results, required 2",
                        res_cycles[i] - res_cycles[i-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_push_pop();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
